parking_slot_manager: RTL and testbench

Sequential front end of the parking occupancy path. Accepts car entry and exit requests from the gate sensors and allocates or frees slots in an 8-bit occupancy register. Drives a timed gate-open signal. The occupancy vector feeds the downstream ones-count stage, which derives the parked-car total.

---
 rtl/parking_slot_manager_pkg.sv | 14 +
 rtl/parking_slot_manager_free_slot_encoder.sv | 25 ++
 rtl/parking_slot_manager.sv | 135 +++++++++++++
 tb/tb_parking_slot_manager.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/parking_slot_manager_pkg.sv
// Shared sizing defaults and FSM state encoding for the parking slot manager.
package parking_slot_manager_pkg;

  localparam int unsigned DEF_NUM_SLOTS   = 8;
  localparam int unsigned DEF_SLOT_W      = 3;
  localparam int unsigned DEF_GATE_CYCLES = 4;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    ENTRY_OPEN = 2'd1,
    EXIT_OPEN  = 2'd2
  } state_t;

endpackage

// File: rtl/parking_slot_manager_free_slot_encoder.sv
// Finds the lowest-index free slot in the occupancy vector.
module free_slot_encoder
  import parking_slot_manager_pkg::*;
#(
  parameter int unsigned NUM_SLOTS = DEF_NUM_SLOTS,
  parameter int unsigned SLOT_W    = DEF_SLOT_W
) (
  input  logic [NUM_SLOTS-1:0] occupancy,
  output logic [SLOT_W-1:0]    free_idx,
  output logic                 free_valid
);

  // Scan high to low so the lowest clear bit is the last one written.
  always_comb begin
    free_idx   = '0;
    free_valid = 1'b0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (!occupancy[i]) begin
        free_idx   = SLOT_W'(i);
        free_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/parking_slot_manager.sv
// Slot allocation/free FSM with a timed gate; occupancy feeds the ones-count stage.
module parking_slot_manager
  import parking_slot_manager_pkg::*;
#(
  parameter int unsigned NUM_SLOTS   = DEF_NUM_SLOTS,
  parameter int unsigned SLOT_W      = DEF_SLOT_W,
  parameter int unsigned GATE_CYCLES = DEF_GATE_CYCLES
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enter_req,
  input  logic                 exit_req,
  input  logic [SLOT_W-1:0]    exit_slot,
  output logic [NUM_SLOTS-1:0] occupancy,
  output logic [SLOT_W-1:0]    assigned_slot,
  output logic                 grant,
  output logic                 deny,
  output logic                 exit_ack,
  output logic                 error,
  output logic                 gate_open,
  output logic                 full,
  output logic                 empty
);

  localparam int unsigned CNT_W = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam int unsigned EXT_W = 2 ** SLOT_W;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(GATE_CYCLES - 1);

  state_t               state, state_nxt;
  logic [CNT_W-1:0]     cnt, cnt_nxt;
  logic [NUM_SLOTS-1:0] occ_nxt;
  logic [SLOT_W-1:0]    slot_nxt;
  logic                 grant_nxt, deny_nxt, exit_ack_nxt, error_nxt, gate_nxt;

  logic [SLOT_W-1:0]    free_idx;
  logic                 free_valid;
  logic [EXT_W-1:0]     occ_ext;
  logic                 exit_hit;
  logic [NUM_SLOTS-1:0] exit_mask, free_mask;

  free_slot_encoder #(
    .NUM_SLOTS (NUM_SLOTS),
    .SLOT_W    (SLOT_W)
  ) u_free_slot_encoder (
    .occupancy  (occupancy),
    .free_idx   (free_idx),
    .free_valid (free_valid)
  );

  // Zero-extend so an out-of-range exit_slot reads as unoccupied.
  assign occ_ext   = EXT_W'(occupancy);
  assign exit_hit  = occ_ext[exit_slot];
  assign exit_mask = NUM_SLOTS'(1) << exit_slot;
  assign free_mask = NUM_SLOTS'(1) << free_idx;

  assign full  = &occupancy;
  assign empty = ~|occupancy;

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    occ_nxt      = occupancy;
    slot_nxt     = assigned_slot;
    grant_nxt    = 1'b0;
    deny_nxt     = 1'b0;
    exit_ack_nxt = 1'b0;
    error_nxt    = 1'b0;
    gate_nxt     = gate_open;
    case (state)
      IDLE: begin
        gate_nxt = 1'b0;
        // Exit has priority over a simultaneous entry.
        if (exit_req) begin
          if (exit_hit) begin
            occ_nxt      = occupancy & ~exit_mask;
            exit_ack_nxt = 1'b1;
            cnt_nxt      = CNT_LOAD;
            gate_nxt     = 1'b1;
            state_nxt    = EXIT_OPEN;
          end else begin
            error_nxt = 1'b1;
          end
        end else if (enter_req) begin
          if (free_valid) begin
            occ_nxt   = occupancy | free_mask;
            slot_nxt  = free_idx;
            grant_nxt = 1'b1;
            cnt_nxt   = CNT_LOAD;
            gate_nxt  = 1'b1;
            state_nxt = ENTRY_OPEN;
          end else begin
            deny_nxt = 1'b1;
          end
        end
      end
      ENTRY_OPEN, EXIT_OPEN: begin
        if (cnt == '0) begin
          state_nxt = IDLE;
          gate_nxt  = 1'b0;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        gate_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      cnt           <= '0;
      occupancy     <= '0;
      assigned_slot <= '0;
      grant         <= 1'b0;
      deny          <= 1'b0;
      exit_ack      <= 1'b0;
      error         <= 1'b0;
      gate_open     <= 1'b0;
    end else begin
      state         <= state_nxt;
      cnt           <= cnt_nxt;
      occupancy     <= occ_nxt;
      assigned_slot <= slot_nxt;
      grant         <= grant_nxt;
      deny          <= deny_nxt;
      exit_ack      <= exit_ack_nxt;
      error         <= error_nxt;
      gate_open     <= gate_nxt;
    end
  end

endmodule

// File: tb/tb_parking_slot_manager.sv
// Directed-vector bench for parking_slot_manager with hand-computed expectations.
module tb_parking_slot_manager;

  logic       clk = 1'b0;
  logic       reset;
  logic       enter_req;
  logic       exit_req;
  logic [2:0] exit_slot;
  logic [7:0] occupancy;
  logic [2:0] assigned_slot;
  logic       grant, deny, exit_ack, error, gate_open, full, empty;

  int vectors = 0;
  int miscompares = 0;

  parking_slot_manager dut (
    .clk           (clk),
    .reset         (reset),
    .enter_req     (enter_req),
    .exit_req      (exit_req),
    .exit_slot     (exit_slot),
    .occupancy     (occupancy),
    .assigned_slot (assigned_slot),
    .grant         (grant),
    .deny          (deny),
    .exit_ack      (exit_ack),
    .error         (error),
    .gate_open     (gate_open),
    .full          (full),
    .empty         (empty)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Hold gate for its remaining 3 cycles plus the closing edge, checking the pulse width.
  task automatic ride_gate(input string tag);
    for (int i = 0; i < 3; i++) begin
      step();
      check({tag, "_gate_hi"}, 32'(gate_open), 32'd1);
    end
    step();
    check({tag, "_gate_lo"}, 32'(gate_open), 32'd0);
  endtask

  task automatic do_enter(input logic [2:0] exp_slot, input logic [7:0] exp_occ);
    enter_req = 1'b1;
    step();
    check("enter_grant", 32'(grant), 32'd1);
    check("enter_slot", 32'(assigned_slot), 32'(exp_slot));
    check("enter_occ", 32'(occupancy), 32'(exp_occ));
    enter_req = 1'b0;
    ride_gate("enter");
  endtask

  initial begin
    reset = 1'b1;
    enter_req = 1'b0;
    exit_req = 1'b0;
    exit_slot = 3'd0;
    #12;
    check("rst_occ", 32'(occupancy), 32'h00);
    check("rst_gate", 32'(gate_open), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full", 32'(full), 32'd0);
    check("rst_slot", 32'(assigned_slot), 32'd0);
    check("rst_grant", 32'(grant), 32'd0);
    reset = 1'b0;
    step();

    // First entry: grant at the sampling edge, gate high for 4 cycles.
    enter_req = 1'b1;
    step();
    check("first_grant", 32'(grant), 32'd1);
    check("first_slot", 32'(assigned_slot), 32'd0);
    check("first_occ", 32'(occupancy), 32'h01);
    check("first_gate", 32'(gate_open), 32'd1);
    check("first_empty", 32'(empty), 32'd0);
    enter_req = 1'b0;
    step();
    check("grant_pulse", 32'(grant), 32'd0);
    check("first_gate2", 32'(gate_open), 32'd1);
    step();
    check("first_gate3", 32'(gate_open), 32'd1);
    step();
    check("first_gate4", 32'(gate_open), 32'd1);
    step();
    check("first_gate_close", 32'(gate_open), 32'd0);

    // Fill the remaining slots in ascending order.
    for (int k = 1; k < 8; k++) begin
      logic [7:0] exp_occ;
      exp_occ = 8'((16'h1 << (k + 1)) - 16'h1);
      do_enter(3'(k), exp_occ);
    end
    check("fill_full", 32'(full), 32'd1);
    check("fill_occ", 32'(occupancy), 32'hFF);

    // Ninth car is refused.
    enter_req = 1'b1;
    step();
    check("deny_pulse", 32'(deny), 32'd1);
    check("deny_grant", 32'(grant), 32'd0);
    check("deny_occ", 32'(occupancy), 32'hFF);
    check("deny_gate", 32'(gate_open), 32'd0);
    enter_req = 1'b0;
    step();
    check("deny_clear", 32'(deny), 32'd0);

    // Free slot 3, then refill it.
    exit_req = 1'b1;
    exit_slot = 3'd3;
    step();
    check("exit_ack", 32'(exit_ack), 32'd1);
    check("exit_occ", 32'(occupancy), 32'hF7);
    check("exit_gate", 32'(gate_open), 32'd1);
    check("exit_notfull", 32'(full), 32'd0);
    exit_req = 1'b0;
    ride_gate("exit");
    do_enter(3'd3, 8'hFF);

    // Exit from an empty lot errors.
    reset = 1'b1;
    #2;
    reset = 1'b0;
    exit_req = 1'b1;
    exit_slot = 3'd5;
    step();
    check("err_pulse", 32'(error), 32'd1);
    check("err_occ", 32'(occupancy), 32'h00);
    check("err_gate", 32'(gate_open), 32'd0);
    exit_req = 1'b0;
    step();
    check("err_clear", 32'(error), 32'd0);

    // Simultaneous requests: exit first, held entry served after the gate closes.
    do_enter(3'd0, 8'h01);
    do_enter(3'd1, 8'h03);
    enter_req = 1'b1;
    exit_req = 1'b1;
    exit_slot = 3'd0;
    step();
    check("both_exit_ack", 32'(exit_ack), 32'd1);
    check("both_no_grant", 32'(grant), 32'd0);
    check("both_occ", 32'(occupancy), 32'h02);
    exit_req = 1'b0;
    ride_gate("both");
    check("both_wait_grant", 32'(grant), 32'd0);
    step();
    check("both_grant", 32'(grant), 32'd1);
    check("both_slot", 32'(assigned_slot), 32'd0);
    check("both_occ2", 32'(occupancy), 32'h03);
    enter_req = 1'b0;
    ride_gate("both2");

    // Reset in the second ENTRY_OPEN cycle acts without a clock edge.
    do_enter(3'd2, 8'h07);
    enter_req = 1'b1;
    step();
    check("mid_occ", 32'(occupancy), 32'h0F);
    enter_req = 1'b0;
    step();
    check("mid_gate", 32'(gate_open), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("async_gate", 32'(gate_open), 32'd0);
    check("async_occ", 32'(occupancy), 32'h00);
    check("async_empty", 32'(empty), 32'd1);
    #2;
    reset = 1'b0;
    step();
    do_enter(3'd0, 8'h01);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
